// File: rtl/multicycle_datapath.sv
// Multicycle RV32I-subset core: regfile, datapath and main control FSM sharing one
// req/ready memory port. XLEN selects a 32- or 64-bit datapath.
module multicycle_datapath #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halt
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] old_pc, a, b, alu_out, data;
  logic [XLEN-1:0] rf [32];

  logic [6:0]      opcode, funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_res, rf_wd;
  logic            is_load, is_store, is_r, is_i, is_beq, is_jal, alu_f3_ok, rf_we;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                (funct3 == 3'b110) || (funct3 == 3'b010);
    is_load   = (opcode == OP_LOAD)  && (funct3 == 3'b010);
    is_store  = (opcode == OP_STORE) && (funct3 == 3'b010);
    is_r      = (opcode == OP_R) &&
                (((funct7 == 7'b0000000) && alu_f3_ok) ||
                 ((funct7 == 7'b0100000) && (funct3 == 3'b000)));
    is_i      = (opcode == OP_I) && alu_f3_ok;
    is_beq    = (opcode == OP_BR) && (funct3 == 3'b000);
    is_jal    = (opcode == OP_JAL);
  end

  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];
  end

  always_comb begin
    alu_b   = (state == EXECI) ? imm_i : b;
    alu_res = '0;
    unique case (funct3)
      3'b000:  alu_res = ((state == EXECR) && funct7[5]) ? a - alu_b : a + alu_b;
      3'b111:  alu_res = a & alu_b;
      3'b110:  alu_res = a | alu_b;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(alu_b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_out;
    unique case (state)
      MEMWB:   begin rf_we = 1'b1; rf_wd = data;          end
      ALUWB:   begin rf_we = 1'b1; rf_wd = alu_out;       end
      JAL:     begin rf_we = 1'b1; rf_wd = old_pc + FOUR; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset && rf_we && (rd != 5'd0)) rf[rd] <= rf_wd;
  end

  // Port outputs decode the registered state directly so a request is visible in the
  // same cycle the FSM enters a memory state; reset masks them immediately.
  always_comb begin
    mem_req   = reset && ((state == FETCH) || (state == MEMRD) || (state == MEMWR));
    mem_we    = reset && (state == MEMWR);
    mem_addr  = (state == FETCH) ? pc : alu_out;
    mem_wdata = b;
    retire    = reset && ((state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                          (state == JAL) || ((state == MEMWR) && mem_ready));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      halt  <= 1'b0;
    end else begin
      unique case (state)
        FETCH: if (mem_ready) begin
          ir     <= mem_rdata[31:0];
          old_pc <= pc;
          pc     <= pc + FOUR;
          state  <= DECODE;
        end
        DECODE: begin
          a <= rs1_val;
          b <= rs2_val;
          if (is_load || is_store) state <= MEMADR;
          else if (is_r)           state <= EXECR;
          else if (is_i)           state <= EXECI;
          else if (is_beq)         state <= BEQ;
          else if (is_jal)         state <= JAL;
          else begin
            state <= TRAP;
            halt  <= 1'b1;
          end
        end
        MEMADR: begin
          alu_out <= a + (is_store ? imm_s : imm_i);
          state   <= is_store ? MEMWR : MEMRD;
        end
        MEMRD: if (mem_ready) begin
          data  <= mem_rdata;
          state <= MEMWB;
        end
        MEMWR: if (mem_ready) state <= FETCH;
        EXECR, EXECI: begin
          alu_out <= alu_res;
          state   <= ALUWB;
        end
        BEQ: begin
          if (a == b) pc <= old_pc + imm_b;
          state <= FETCH;
        end
        JAL: begin
          pc    <= old_pc + imm_j;
          state <= FETCH;
        end
        MEMWB, ALUWB: state <= FETCH;
        TRAP:         state <= TRAP;
        default:      state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: 32-bit core with a wait-state memory model,
// plus a 64-bit instance for width checks.
module tb_multicycle_datapath;

  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset, mem_req, mem_we, mem_ready, retire, halt;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

  logic        reset64, mem_req64, mem_we64, mem_ready64, retire64, halt64;
  logic [63:0] mem_addr64, mem_wdata64, mem_rdata64, pc64;

  multicycle_datapath #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .pc(pc),
    .retire(retire), .halt(halt));

  multicycle_datapath #(.XLEN(64), .RESET_PC(64'h0)) dut64 (
    .clk(clk), .reset(reset64), .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64),
    .mem_wdata(mem_wdata64), .mem_ready(mem_ready64), .mem_rdata(mem_rdata64), .pc(pc64),
    .retire(retire64), .halt(halt64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [256];
  logic [31:0] prog64 [8];
  int unsigned fetch_wait, data_wait, wcnt, cyc, hs_viol, req_cnt;
  logic        hs_pend, hs_we, prev_retire;
  logic [31:0] hs_addr, hs_wdata;
  int unsigned retire_q [$];
  logic [31:0] pc_q [$];
  logic [63:0] w64_addr [$];
  logic [63:0] w64_data [$];

  // RV32I encoders
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    logic [31:0] i, s, f, d, o;
    i = imm; s = rs1; f = f3; d = rd; o = op;
    return {i[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    logic [31:0] g, t, s, f, d;
    g = f7; t = rs2; s = rs1; f = f3; d = rd;
    return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_sw(int imm, int rs2, int rs1);
    logic [31:0] i, t, s;
    i = imm; t = rs2; s = rs1;
    return {i[11:5], t[4:0], s[4:0], 3'b010, i[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_beq(int imm, int rs2, int rs1);
    logic [31:0] i, t, s;
    i = imm; t = rs2; s = rs1;
    return {i[12], i[10:5], t[4:0], s[4:0], 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_jal(int imm, int rd);
    logic [31:0] i, d;
    i = imm; d = rd;
    return {i[20], i[10:1], i[11], i[19:12], d[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 7'b0010011);
  endfunction

  task automatic put(int idx, logic [31:0] w);
    mem[64 + idx] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  // One clock of the 32-bit core with the wait-state memory; entered and left at negedge.
  task automatic tick();
    int unsigned need;
    logic s_req, s_we, s_rdy;
    logic [31:0] s_addr, s_wdata;
    #1;
    cyc++;
    if (!reset) begin hs_pend = 1'b0; wcnt = 0; end
    need = (mem_addr < 32'h100) ? data_wait : fetch_wait;
    mem_ready = mem_req && (wcnt >= need);
    mem_rdata = mem[mem_addr[9:2]];
    #1;
    if (hs_pend && (!mem_req || mem_addr !== hs_addr || mem_we !== hs_we ||
                    (hs_we && mem_wdata !== hs_wdata))) hs_viol++;
    hs_pend = mem_req && !mem_ready;
    hs_addr = mem_addr; hs_we = mem_we; hs_wdata = mem_wdata;
    if (prev_retire) pc_q.push_back(pc);
    prev_retire = retire;
    if (retire) retire_q.push_back(cyc);
    if (mem_req) req_cnt++;
    s_req = mem_req; s_we = mem_we; s_rdy = mem_ready; s_addr = mem_addr; s_wdata = mem_wdata;
    @(posedge clk);
    if (s_req && s_rdy) begin
      wcnt = 0;
      if (s_we) mem[s_addr[9:2]] = s_wdata;
    end else if (s_req) wcnt++;
    else wcnt = 0;
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run(3);
    retire_q.delete(); pc_q.delete();
    prev_retire = 1'b0; hs_pend = 1'b0; wcnt = 0; hs_viol = 0; req_cnt = 0;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic tick64();
    #1;
    mem_ready64 = mem_req64;
    mem_rdata64 = {32'h0, prog64[mem_addr64[4:2]]};
    #1;
    if (mem_req64 && mem_we64) begin
      w64_addr.push_back(mem_addr64);
      w64_data.push_back(mem_wdata64);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_mem();
    put(0, addi(1, 0, 5));
    reset = 1'b0;
    run(3);
    n_tests++; if (pc !== 32'h100) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h100); end
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b expected 0", halt); end
    reset = 1'b1;
    #1;
    n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL first_fetch_req: got %b expected 1", mem_req); end
    n_tests++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL first_fetch_addr: got %h expected %h", mem_addr, 32'h100); end
    @(negedge clk);
  endtask

  task automatic test_alu();
    clear_mem();
    fetch_wait = 0; data_wait = 0;
    put(0, addi(1, 0, 5));
    put(1, addi(2, 0, -3));
    put(2, enc_r(0, 2, 1, 0, 3));
    put(3, enc_r(0, 1, 2, 2, 4));
    put(4, enc_sw(16, 3, 0));
    put(5, enc_sw(20, 4, 0));
    put(6, enc_jal(0, 0));
    mem[4] = SENT; mem[5] = SENT;
    do_reset();
    run(30);
    n_tests++; if (retire_q[0] !== 4) begin n_fail++; $display("FAIL retire_1: got %0d expected 4", retire_q[0]); end
    n_tests++; if (retire_q[1] !== 8) begin n_fail++; $display("FAIL retire_2: got %0d expected 8", retire_q[1]); end
    n_tests++; if (retire_q[2] !== 12) begin n_fail++; $display("FAIL retire_3: got %0d expected 12", retire_q[2]); end
    n_tests++; if (retire_q[3] !== 16) begin n_fail++; $display("FAIL retire_4: got %0d expected 16", retire_q[3]); end
    n_tests++; if (mem[4] !== 32'd2) begin n_fail++; $display("FAIL add_x3: got %h expected %h", mem[4], 32'd2); end
    n_tests++; if (mem[5] !== 32'd1) begin n_fail++; $display("FAIL slt_x4: got %h expected %h", mem[5], 32'd1); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp_v [8];
    exp_v = '{32'd8, 32'd5, 32'hFFFF_FFFD, 32'h0000_00F0, 32'hFFFF_FFF5, 32'd0, 32'd0, 32'd0};
    clear_mem();
    put(0, addi(1, 0, 5));
    put(1, addi(2, 0, -3));
    put(2, enc_r(32, 2, 1, 0, 5));
    put(3, enc_r(0, 2, 1, 7, 6));
    put(4, enc_r(0, 2, 1, 6, 7));
    put(5, enc_i(32'hF0, 2, 7, 8, 7'b0010011));
    put(6, enc_i(-16, 1, 6, 9, 7'b0010011));
    put(7, enc_i(-1, 1, 2, 10, 7'b0010011));
    put(8, enc_r(0, 2, 1, 2, 11));
    put(9, addi(0, 0, 7));
    for (int i = 0; i < 7; i++) put(10 + i, enc_sw(64 + 4 * i, 5 + i, 0));
    put(17, enc_sw(92, 0, 0));
    put(18, enc_jal(0, 0));
    for (int i = 16; i < 24; i++) mem[i] = SENT;
    do_reset();
    run(80);
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (mem[16 + i] !== exp_v[i]) begin
        n_fail++; $display("FAIL alu_op_%0d: got %h expected %h", i, mem[16 + i], exp_v[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    clear_mem();
    put(0, addi(1, 0, 5));
    put(1, enc_sw(8, 1, 0));
    put(2, enc_i(8, 0, 2, 5, 7'b0000011));
    put(3, enc_sw(12, 5, 0));
    put(4, enc_jal(0, 0));
    mem[2] = SENT; mem[3] = SENT;
    fetch_wait = 0; data_wait = 3;
    do_reset();
    run(34);
    n_tests++; if (retire_q[1] !== 11) begin n_fail++; $display("FAIL sw_wait_retire: got %0d expected 11", retire_q[1]); end
    n_tests++; if (retire_q[2] - retire_q[1] !== 8) begin n_fail++; $display("FAIL lw_wait_cycles: got %0d expected 8", retire_q[2] - retire_q[1]); end
    n_tests++; if (mem[2] !== 32'd5) begin n_fail++; $display("FAIL sw_data: got %h expected %h", mem[2], 32'd5); end
    n_tests++; if (mem[3] !== 32'd5) begin n_fail++; $display("FAIL lw_x5: got %h expected %h", mem[3], 32'd5); end
    n_tests++; if (hs_viol !== 0) begin n_fail++; $display("FAIL handshake_stable: got %0d violations expected 0", hs_viol); end
    data_wait = 0;
  endtask

  task automatic test_branch();
    int unsigned exp_r [6];
    logic [31:0] exp_pc [6];
    exp_r  = '{4, 8, 11, 14, 18, 21};
    exp_pc = '{32'h104, 32'h108, 32'h10C, 32'h11C, 32'h120, 32'h118};
    clear_mem();
    put(0, addi(1, 0, 5));
    put(1, addi(2, 0, -3));
    put(2, enc_beq(64, 2, 1));
    put(3, enc_jal(16, 6));
    put(4, 32'h0000_007F);
    put(5, 32'h0000_007F);
    put(6, enc_jal(0, 0));
    put(7, enc_sw(32, 6, 0));
    put(8, enc_beq(-8, 1, 1));
    mem[8] = SENT;
    do_reset();
    run(30);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (retire_q[i] !== exp_r[i]) begin
        n_fail++; $display("FAIL br_retire_%0d: got %0d expected %0d", i, retire_q[i], exp_r[i]);
      end
      n_tests++;
      if (pc_q[i] !== exp_pc[i]) begin
        n_fail++; $display("FAIL br_pc_%0d: got %h expected %h", i, pc_q[i], exp_pc[i]);
      end
    end
    n_tests++; if (mem[8] !== 32'h110) begin n_fail++; $display("FAIL jal_link: got %h expected %h", mem[8], 32'h110); end
    n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL br_no_halt: got %b expected 0", halt); end
  endtask

  task automatic test_trap();
    clear_mem();
    put(0, 32'h0000_007F);
    do_reset();
    run(2);
    n_tests++; if (halt !== 1'b1) begin n_fail++; $display("FAIL trap_halt: got %b expected 1", halt); end
    req_cnt = 0;
    run(20);
    n_tests++; if (req_cnt !== 0) begin n_fail++; $display("FAIL trap_no_req: got %0d expected 0", req_cnt); end
    n_tests++; if (pc !== 32'h104) begin n_fail++; $display("FAIL trap_pc: got %h expected %h", pc, 32'h104); end
    n_tests++; if (retire_q.size() !== 0) begin n_fail++; $display("FAIL trap_no_retire: got %0d expected 0", retire_q.size()); end
    reset = 1'b0;
    tick();
    n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL trap_reset_clears: got %b expected 0", halt); end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    put(0, addi(1, 0, 9));
    put(1, addi(1, 0, 1));
    fetch_wait = 0;
    do_reset();
    run(4);
    fetch_wait = 10;
    run(2);
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin n_fail++; $display("FAIL mid_pending: got req %b addr %h expected req 1 addr %h", mem_req, mem_addr, 32'h104); end
    reset = 1'b0;
    #1;
    n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req_drop: got %b expected 0", mem_req); end
    tick();
    n_tests++; if (mem_req !== 1'b0 || pc !== 32'h100) begin n_fail++; $display("FAIL mid_after: got req %b pc %h expected req 0 pc %h", mem_req, pc, 32'h100); end
    tick();
    put(0, enc_sw(48, 1, 0));
    put(1, enc_jal(0, 0));
    mem[12] = SENT;
    fetch_wait = 0;
    reset = 1'b1;
    run(8);
    n_tests++; if (mem[12] !== 32'd9) begin n_fail++; $display("FAIL mid_regs_kept: got %h expected %h", mem[12], 32'd9); end
  endtask

  task automatic test_xlen64();
    reset = 1'b0;
    prog64[0] = addi(1, 0, -1);
    prog64[1] = addi(2, 0, 1);
    prog64[2] = enc_r(0, 2, 1, 0, 3);
    prog64[3] = enc_sw(16, 1, 0);
    prog64[4] = enc_sw(24, 3, 0);
    prog64[5] = enc_jal(0, 0);
    prog64[6] = 32'h0; prog64[7] = 32'h0;
    reset64 = 1'b0;
    tick64(); tick64();
    n_tests++; if (pc64 !== 64'h0) begin n_fail++; $display("FAIL x64_reset_pc: got %h expected 0", pc64); end
    reset64 = 1'b1;
    for (int i = 0; i < 26; i++) tick64();
    n_tests++; if (w64_addr[0] !== 64'd16) begin n_fail++; $display("FAIL x64_sw_addr: got %h expected %h", w64_addr[0], 64'd16); end
    n_tests++; if (w64_data[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL x64_addi_m1: got %h expected %h", w64_data[0], 64'hFFFF_FFFF_FFFF_FFFF); end
    n_tests++; if (w64_data[1] !== 64'h0) begin n_fail++; $display("FAIL x64_add_wrap: got %h expected 0", w64_data[1]); end
    reset64 = 1'b0;
    mem_ready64 = 1'b0;
    tick64();
  endtask

  initial begin
    reset = 1'b0; reset64 = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    mem_ready64 = 1'b0; mem_rdata64 = '0;
    fetch_wait = 0; data_wait = 0; wcnt = 0; cyc = 0;
    hs_viol = 0; req_cnt = 0; hs_pend = 1'b0; prev_retire = 1'b0;
    hs_we = 1'b0; hs_addr = '0; hs_wdata = '0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_alu_ops();
    test_mem_wait();
    test_branch();
    test_trap();
    test_reset_mid();
    test_xlen64();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
